// File: rtl/hex_step_counter_pkg.sv
// Shared definitions for the hex step counter and the 7-segment decoder
// that displays its digit.
package hex_step_counter_pkg;

   localparam int unsigned HEX_W         = 4;
   localparam int unsigned DIV_DEF       = 12_000_000;
   localparam int unsigned DIV_W_DEF     = 24;
   localparam int unsigned DB_CYCLES_DEF = 120_000;
   localparam int unsigned DB_W_DEF      = 17;

   typedef logic [HEX_W-1:0] hex_t;

   // Source of the step applied to the digit in a given cycle.
   typedef enum logic [1:0] {
      EV_NONE,
      EV_AUTO,
      EV_STEP
   } ev_src_e;

   // Active-high segments {g,f,e,d,c,b,a}, indexed by hex digit.
   localparam logic [6:0] SEG_LUT [16] = '{
      7'h3F, 7'h06, 7'h5B, 7'h4F,
      7'h66, 7'h6D, 7'h7D, 7'h07,
      7'h7F, 7'h6F, 7'h77, 7'h7C,
      7'h39, 7'h5E, 7'h79, 7'h71
   };

   function automatic hex_t hex_step(input hex_t v, input logic up);
      return up ? v + hex_t'(1) : v - hex_t'(1);
   endfunction

   function automatic logic hex_wraps(input hex_t v, input logic up);
      return up ? (v == '1) : (v == '0);
   endfunction

endpackage

// File: rtl/hex_step_counter_debounce.sv
// Button conditioning: 2-flop synchroniser, stability counter and a
// registered one-cycle pulse on each accepted press.
module button_debounce
   import hex_step_counter_pkg::*;
#(
   parameter int unsigned DB_CYCLES = DB_CYCLES_DEF,
   parameter int unsigned DB_W      = DB_W_DEF
) (
   input  logic clk,
   input  logic rst_n,
   input  logic btn_raw,
   output logic btn_level,
   output logic btn_rise
);

   localparam logic [DB_W-1:0] CNT_LAST = DB_W'(DB_CYCLES - 1);

   logic            sync1_q;
   logic            sync2_q;
   logic            level_q;
   logic            level_d;
   logic            rise_q;
   logic            rise_d;
   logic [DB_W-1:0] cnt_q;
   logic [DB_W-1:0] cnt_d;

   // Any sample agreeing with the level restarts qualification.
   always_comb begin
      level_d = level_q;
      rise_d  = 1'b0;
      cnt_d   = '0;
      if (sync2_q != level_q) begin
         if (cnt_q == CNT_LAST) begin
            level_d = sync2_q;
            rise_d  = sync2_q;
         end else begin
            cnt_d = cnt_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
         level_q <= 1'b0;
         rise_q  <= 1'b0;
         cnt_q   <= '0;
      end else begin
         sync1_q <= btn_raw;
         sync2_q <= sync1_q;
         level_q <= level_d;
         rise_q  <= rise_d;
         cnt_q   <= cnt_d;
      end
   end

   assign btn_level = level_q;
   assign btn_rise  = rise_q;

endmodule

// File: rtl/hex_step_counter.sv
// Hex digit source for the 7-segment display: prescaled auto-step or
// debounced single-step, with synchronous clear.
module hex_step_counter
   import hex_step_counter_pkg::*;
#(
   parameter int unsigned DIV       = DIV_DEF,
   parameter int unsigned DIV_W     = DIV_W_DEF,
   parameter int unsigned DB_CYCLES = DB_CYCLES_DEF,
   parameter int unsigned DB_W      = DB_W_DEF
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             run,
   input  logic             up,
   input  logic             clr,
   input  logic             step_btn,
   output logic [HEX_W-1:0] count,
   output logic             tick,
   output logic             carry
);

   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);

   logic             btn_level;
   logic             btn_rise;
   logic [DIV_W-1:0] div_q;
   logic [DIV_W-1:0] div_d;
   logic             div_wrap;
   logic             auto_ev;
   logic             step_ev;
   ev_src_e          ev_src;
   hex_t             count_q;
   hex_t             count_d;
   logic             tick_q;
   logic             tick_d;
   logic             carry_q;
   logic             carry_d;

   button_debounce #(
      .DB_CYCLES (DB_CYCLES),
      .DB_W      (DB_W)
   ) u_debounce (
      .clk       (clk),
      .rst_n     (rst_n),
      .btn_raw   (step_btn),
      .btn_level (btn_level),
      .btn_rise  (btn_rise)
   );

   assign div_wrap = (div_q == DIV_LAST);
   assign auto_ev  = run & div_wrap;
   // Presses while running are dropped, never queued.
   assign step_ev  = btn_rise & btn_level & ~run;

   always_comb begin
      div_d = div_q + 1'b1;
      if (clr || !run || div_wrap) begin
         div_d = '0;
      end
   end

   always_comb begin
      ev_src = EV_NONE;
      unique case (1'b1)
         auto_ev: ev_src = EV_AUTO;
         step_ev: ev_src = EV_STEP;
         default: ev_src = EV_NONE;
      endcase
   end

   always_comb begin
      count_d = count_q;
      tick_d  = 1'b0;
      carry_d = 1'b0;
      if (!clr && ev_src != EV_NONE) begin
         count_d = hex_step(count_q, up);
         tick_d  = 1'b1;
         carry_d = hex_wraps(count_q, up);
      end else if (clr) begin
         count_d = '0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         div_q   <= '0;
         count_q <= '0;
         tick_q  <= 1'b0;
         carry_q <= 1'b0;
      end else begin
         div_q   <= div_d;
         count_q <= count_d;
         tick_q  <= tick_d;
         carry_q <= carry_d;
      end
   end

   assign count = count_q;
   assign tick  = tick_q;
   assign carry = carry_q;

endmodule

// File: tb/tb_hex_step_counter.sv
// Self-checking bench for hex_step_counter: directed scenarios plus a
// randomized run against a cycle-level reference model.
module tb_hex_step_counter;

   localparam int DIV = 4;
   localparam int DB  = 3;

   logic       clk      = 1'b0;
   logic       rst_n    = 1'b0;
   logic       run      = 1'b0;
   logic       up       = 1'b1;
   logic       clr      = 1'b0;
   logic       step_btn = 1'b0;
   logic [3:0] count;
   logic       tick;
   logic       carry;

   int checks = 0;
   int errors = 0;

   hex_step_counter #(
      .DIV       (DIV),
      .DIV_W     (3),
      .DB_CYCLES (DB),
      .DB_W      (2)
   ) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .run      (run),
      .up       (up),
      .clr      (clr),
      .step_btn (step_btn),
      .count    (count),
      .tick     (tick),
      .carry    (carry)
   );

   always #5 clk = ~clk;

   // Reference model state: digit, clocks into the current period,
   // debounced level, pending press and the raw samples since reset.
   int m_count;
   int m_phase;
   bit m_tick;
   bit m_carry;
   bit m_lvl;
   bit m_rise;
   bit raw_hist[$];

   function automatic bit sync_at(int j);
      if (j < 2) return 1'b0;
      return raw_hist[j-2];
   endfunction

   task automatic model_reset();
      m_count = 0;
      m_phase = 0;
      m_tick  = 0;
      m_carry = 0;
      m_lvl   = 0;
      m_rise  = 0;
      raw_hist.delete();
   endtask

   task automatic model_edge();
      int n;
      bit flip;
      bit step;
      bit autoe;
      n     = raw_hist.size();
      flip  = 1'b1;
      for (int j = n - DB + 1; j <= n; j++)
         if (sync_at(j) == m_lvl) flip = 1'b0;
      step  = m_rise && !run;
      autoe = run && (m_phase == DIV - 1);
      if (clr) begin
         m_count = 0;
         m_phase = 0;
         m_tick  = 0;
         m_carry = 0;
      end else begin
         m_phase = run ? (m_phase + 1) % DIV : 0;
         if (step || autoe) begin
            m_carry = up ? (m_count == 15) : (m_count == 0);
            m_count = (m_count + (up ? 1 : 15)) % 16;
            m_tick  = 1;
         end else begin
            m_tick  = 0;
            m_carry = 0;
         end
      end
      m_rise = flip && !m_lvl;
      if (flip) m_lvl = !m_lvl;
      raw_hist.push_back(step_btn);
   endtask

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
      end
   endtask

   logic [3:0] m_cnt4;

   task automatic cyc();
      @(posedge clk);
      if (rst_n) model_edge();
      @(negedge clk);
      m_cnt4 = 4'(m_count);
      check("model_count", count, m_cnt4);
      check("model_tick", tick, m_tick);
      check("model_carry", carry, m_carry);
   endtask

   // Called just after a falling edge; finishes before the next rise.
   task automatic pulse_reset();
      #1 rst_n = 1'b0;
      #1;
      check("rst_count", count, 4'h0);
      check("rst_tick", tick, 1'b0);
      check("rst_carry", carry, 1'b0);
      model_reset();
      #1 rst_n = 1'b1;
   endtask

   initial begin
      int ticks;
      int at;
      int hold;
      int c0;
      bit pat [4];
      model_reset();
      @(negedge clk);
      check("init_count", count, 4'h0);
      check("init_tick", tick, 1'b0);
      @(negedge clk);
      rst_n = 1'b1;

      // Reach count 7, then reset asynchronously between edges.
      run = 1'b1;
      up  = 1'b1;
      repeat (28) cyc();
      check("t1_pre", count, 4'h7);
      run = 1'b0;
      pulse_reset();

      // Count up through a full wrap.
      run = 1'b1;
      for (int i = 1; i <= 16; i++) begin
         repeat (3) begin
            cyc();
            check("t2_idle", tick, 1'b0);
         end
         cyc();
         check("t2_tick", tick, 1'b1);
         check("t2_count", count, 32'(i % 16));
         check("t2_carry", carry, (i == 16) ? 32'd1 : 32'd0);
      end

      // Count down across the 0 -> F wrap.
      up = 1'b0;
      repeat (4) cyc();
      check("t3_count1", count, 4'hF);
      check("t3_carry1", carry, 1'b1);
      repeat (4) cyc();
      check("t3_count2", count, 4'hE);
      check("t3_carry2", carry, 1'b0);

      // Bounce, hold, release while paused: exactly one step.
      run = 1'b0;
      up  = 1'b1;
      repeat (3) cyc();
      pat   = '{1'b1, 1'b0, 1'b1, 1'b0};
      ticks = 0;
      at    = -1;
      for (int i = 0; i < 26; i++) begin
         if (i < 4) step_btn = pat[i];
         else step_btn = (i < 16);
         cyc();
         if (tick === 1'b1) begin
            ticks++;
            at = i;
         end
      end
      check("t4_steps", ticks, 1);
      check("t4_edge", at, 4 + DB + 2);
      check("t4_count", count, 4'hF);

      // Clear on the tick cycle, then press while running.
      run = 1'b1;
      for (int i = 0; i < 8 && m_phase != DIV - 1; i++) cyc();
      check("t5_phase", m_phase, DIV - 1);
      clr = 1'b1;
      cyc();
      check("t5_clr_count", count, 4'h0);
      check("t5_clr_tick", tick, 1'b0);
      clr = 1'b0;
      repeat (3) begin
         cyc();
         check("t5_idle", tick, 1'b0);
      end
      cyc();
      check("t5_tick", tick, 1'b1);
      check("t5_count", count, 4'h1);
      c0    = 1;
      ticks = 0;
      for (int i = 0; i < 16; i++) begin
         step_btn = (i < 10);
         cyc();
         if (tick === 1'b1) ticks++;
      end
      check("t5_run_ticks", ticks, 4);
      check("t5_run_count", count, 32'(c0 + 4));

      // Reset in the middle of a held press while paused.
      run      = 1'b0;
      step_btn = 1'b1;
      repeat (2) cyc();
      pulse_reset();
      for (int i = 0; i < DB + 3; i++) begin
         cyc();
         if (i < DB + 2) begin
            check("t6_wait_count", count, 4'h0);
            check("t6_wait_tick", tick, 1'b0);
         end else begin
            check("t6_count", count, 4'h1);
            check("t6_tick", tick, 1'b1);
         end
      end
      step_btn = 1'b0;
      repeat (8) cyc();
      check("t6_after", count, 4'h1);

      // Randomized traffic against the model.
      hold = 0;
      for (int i = 0; i < 600; i++) begin
         if ($urandom_range(0, 15) == 0) run = ~run;
         up  = 1'($urandom_range(0, 1));
         clr = ($urandom_range(0, 24) == 0);
         if (hold == 0) begin
            step_btn = 1'($urandom_range(0, 1));
            hold     = int'($urandom_range(1, 9));
         end
         hold--;
         if ($urandom_range(0, 199) == 0) pulse_reset();
         cyc();
      end
      clr = 1'b0;

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
